mac_tile_stream: RTL

//  Parametrised successor to the 16-lane MAC array: LANES lanes each dot one A vector with a shared B vector per beat.

---
 rtl/mac_pkg.sv | 33 +++
 rtl/mac_stream_lane.sv | 119 +++++++++++
 rtl/mac_tile_stream.sv | 119 +++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// Shared definitions for the MAC blocks (mac_16 and mac_tile_stream).
//  MODE_INT8/MODE_INT4 : operand encodings selected by cfg_mode
//  DOT8_W/DOT4_W       : per-beat dot-product widths for 32-byte vectors
//  sat_to()            : clamp a wide signed value to a w-bit signed range
package mac_pkg;

    localparam logic MODE_INT8 = 1'b0;
    localparam logic MODE_INT4 = 1'b1;

    localparam int unsigned DOT8_W = 21;
    localparam int unsigned DOT4_W = 14;

    // Width of the scale/accumulate intermediates; wide enough that nothing wraps.
    localparam int unsigned WIDE_W = 64;

    function automatic logic signed [WIDE_W-1:0] sat_to(
        input logic signed [WIDE_W-1:0] v,
        input int unsigned              w
    );
        logic signed [WIDE_W-1:0] hi;
        logic signed [WIDE_W-1:0] lo;
        hi = (64'sd1 <<< (w - 32'd1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/mac_stream_lane.sv
// One MAC lane: int8/int4 dot product of its A vector with the shared B vector,
// S1 register, optional VSQ scaling, saturating accumulate and sticky sat flag.
// Ports:
//  clk, rst             clock, async active-high reset
//  mode                 operand mode for the beat being loaded
//  load                 beat accepted this edge: capture dot and a_scale into S1
//  a_op                 A vector with its scale in the top SCALE_W bits
//  b_vec                shared B vector (data bytes only)
//  step                 S1 holds a beat that is consumed this edge
//  s1_last, s1_vsq      tile-end flag and VSQ enable of the S1 beat
//  s1_bscale            B scale of the S1 beat
//  out_acc, out_sat     tile result and saturation flag, written on the last step
module mac_stream_lane
    import mac_pkg::*;
#(
    parameter int unsigned VEC_LEN   = 32,
    parameter int unsigned SCALE_W   = 8,
    parameter int unsigned ACC_W     = 24,
    parameter int unsigned VSQ_SHIFT = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       mode,
    input  logic                       load,
    input  logic [VEC_LEN*8+SCALE_W-1:0] a_op,
    input  logic [VEC_LEN*8-1:0]       b_vec,
    input  logic                       step,
    input  logic                       s1_last,
    input  logic                       s1_vsq,
    input  logic [SCALE_W-1:0]         s1_bscale,
    output logic [ACC_W-1:0]           out_acc,
    output logic                       out_sat
);

    localparam int unsigned VEC_W = VEC_LEN * 8;

    logic signed [15:0]         p8;
    logic signed [7:0]          p4_lo;
    logic signed [7:0]          p4_hi;
    logic signed [DOT8_W-1:0]   sum8;
    logic signed [DOT4_W-1:0]   sum4;
    logic signed [DOT8_W-1:0]   dot_c;

    logic signed [DOT8_W-1:0]   s1_dot;
    logic [SCALE_W-1:0]         s1_ascale;
    logic signed [ACC_W-1:0]    acc_q;
    logic                       sat_q;

    logic signed [WIDE_W-1:0]   term_w;
    logic signed [WIDE_W-1:0]   term_s;
    logic signed [WIDE_W-1:0]   sum_w;
    logic signed [WIDE_W-1:0]   sum_s;
    logic signed [ACC_W-1:0]    acc_next;
    logic                       sat_next;

    // Dot product of the incoming beat in both encodings; mode picks one.
    always_comb begin
        sum8  = '0;
        sum4  = '0;
        p8    = '0;
        p4_lo = '0;
        p4_hi = '0;
        for (int unsigned i = 0; i < VEC_LEN; i++) begin
            p8    = 16'($signed(a_op[i*8 +: 8])) * 16'($signed(b_vec[i*8 +: 8]));
            p4_lo = 8'($signed(a_op[i*8 +: 4])) * 8'($signed(b_vec[i*8 +: 4]));
            p4_hi = 8'($signed(a_op[i*8+4 +: 4])) * 8'($signed(b_vec[i*8+4 +: 4]));
            sum8  = sum8 + DOT8_W'(p8);
            sum4  = sum4 + DOT4_W'(p4_lo) + DOT4_W'(p4_hi);
        end
        case (mode)
            MODE_INT8: dot_c = sum8;
            MODE_INT4: dot_c = DOT8_W'(sum4);
            default:   dot_c = sum8;
        endcase
    end

    // Scale the S1 dot (if enabled) and fold it into the accumulator with clamping.
    always_comb begin
        term_w = WIDE_W'(s1_dot);
        if (s1_vsq) begin
            term_w = (WIDE_W'(s1_dot) * $signed(WIDE_W'(s1_ascale))
                      * $signed(WIDE_W'(s1_bscale))) >>> VSQ_SHIFT;
        end
        term_s   = sat_to(term_w, ACC_W);
        sum_w    = WIDE_W'(acc_q) + term_s;
        sum_s    = sat_to(sum_w, ACC_W);
        acc_next = ACC_W'(sum_s);
        sat_next = sat_q | (term_s != term_w) | (sum_s != sum_w);
    end

    // S1 capture, accumulate, and tile hand-off into the output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_dot    <= '0;
            s1_ascale <= '0;
            acc_q     <= '0;
            sat_q     <= 1'b0;
            out_acc   <= '0;
            out_sat   <= 1'b0;
        end else begin
            if (load) begin
                s1_dot    <= dot_c;
                s1_ascale <= a_op[VEC_W +: SCALE_W];
            end
            if (step) begin
                if (s1_last) begin
                    out_acc <= acc_next;
                    out_sat <= sat_next;
                    acc_q   <= '0;
                    sat_q   <= 1'b0;
                end else begin
                    acc_q <= acc_next;
                    sat_q <= sat_next;
                end
            end
        end
    end

endmodule

// File: rtl/mac_tile_stream.sv
// LANES-wide streaming MAC tile: each lane dots its A vector with a shared B
// vector per beat, accumulates over a K-tile framed by in_last, and presents the
// tile result on a valid/ready port.
// Ports:
//  clk, rst             clock, async active-high reset
//  cfg_mode, cfg_vsq    operand mode / VSQ enable, latched on a tile's first beat
//  in_valid, in_ready   operand beat handshake
//  in_a, in_b, in_last  per-lane A operands, shared B operand, tile-end flag
//  out_valid, out_ready result handshake
//  out_acc, out_sat     per-lane signed results and sticky saturation flags
module mac_tile_stream
    import mac_pkg::*;
#(
    parameter int unsigned LANES     = 16,
    parameter int unsigned VEC_LEN   = 32,
    parameter int unsigned SCALE_W   = 8,
    parameter int unsigned ACC_W     = 24,
    parameter int unsigned VSQ_SHIFT = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               cfg_mode,
    input  logic                               cfg_vsq,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [LANES*(VEC_LEN*8+SCALE_W)-1:0] in_a,
    input  logic [VEC_LEN*8+SCALE_W-1:0]       in_b,
    input  logic                               in_last,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [LANES*ACC_W-1:0]             out_acc,
    output logic [LANES-1:0]                   out_sat
);

    localparam int unsigned VEC_W = VEC_LEN * 8;
    localparam int unsigned OP_W  = VEC_W + SCALE_W;

    logic               tile_open;
    logic               mode_q;
    logic               vsq_q;
    logic               s1_valid;
    logic               s1_last;
    logic               s1_vsq;
    logic [SCALE_W-1:0] s1_bscale;

    logic stall;
    logic accept;
    logic step;
    logic mode_eff;
    logic vsq_eff;

    // A finished tile in S1 cannot retire while the previous result is unconsumed.
    assign stall    = s1_valid & s1_last & out_valid & ~out_ready;
    assign in_ready = ~stall;
    assign accept   = in_valid & in_ready;
    assign step     = s1_valid & ~stall;

    // First beat of a tile uses the live config; later beats use the latched copy.
    assign mode_eff = tile_open ? mode_q : cfg_mode;
    assign vsq_eff  = tile_open ? vsq_q  : cfg_vsq;

    // Handshake, S1 control, tile framing and config latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tile_open <= 1'b0;
            mode_q    <= 1'b0;
            vsq_q     <= 1'b0;
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            s1_vsq    <= 1'b0;
            s1_bscale <= '0;
            out_valid <= 1'b0;
        end else begin
            if (accept) begin
                s1_valid  <= 1'b1;
                s1_last   <= in_last;
                s1_vsq    <= vsq_eff;
                s1_bscale <= in_b[VEC_W +: SCALE_W];
                tile_open <= ~in_last;
                if (!tile_open) begin
                    mode_q <= cfg_mode;
                    vsq_q  <= cfg_vsq;
                end
            end else if (step) begin
                s1_valid <= 1'b0;
            end

            // A new result may load on the same edge the old one is taken.
            if (step && s1_last) begin
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        mac_stream_lane #(
            .VEC_LEN   (VEC_LEN),
            .SCALE_W   (SCALE_W),
            .ACC_W     (ACC_W),
            .VSQ_SHIFT (VSQ_SHIFT)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .mode      (mode_eff),
            .load      (accept),
            .a_op      (in_a[l*OP_W +: OP_W]),
            .b_vec     (in_b[VEC_W-1:0]),
            .step      (step),
            .s1_last   (s1_last),
            .s1_vsq    (s1_vsq),
            .s1_bscale (s1_bscale),
            .out_acc   (out_acc[l*ACC_W +: ACC_W]),
            .out_sat   (out_sat[l])
        );
    end

endmodule
